// File: rtl/mau_pkg.sv
// Shared definitions for the load/store sequencer: size encodings, FSM states
// and the accept-to-response latencies of each request class.
package mau_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RDW  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } mau_state_t;

  // Cycles from the accept edge to the resp_valid cycle
  localparam int LAT_ERR = 1;
  localparam int LAT_WST = 2;
  localparam int LAT_LD  = 3;
  localparam int LAT_SST = 4;

endpackage

// File: rtl/mau_format.sv
// Combinational data formatting: extracts and extends load data from the
// captured big-endian word, and merges sub-word store data into it.
module mau_format
  import mau_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [DW-1:0] rd,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] ld_data,
  output logic [DW-1:0] st_data
);

  function automatic logic [DW-1:0] ext8(input logic [7:0] b, input logic s);
    return {{(DW-8){s & b[7]}}, b};
  endfunction

  function automatic logic [DW-1:0] ext16(input logic [15:0] h, input logic s);
    return {{(DW-16){s & h[15]}}, h};
  endfunction

  // The addressed byte sits on the top lane; stores replace the top lanes only
  always_comb begin
    ld_data = '0;
    st_data = '0;
    case (size)
      SZ_B: begin
        ld_data = ext8(rd[DW-1 -: 8], sext);
        st_data = {wdata[7:0], rd[DW-9:0]};
      end
      SZ_H: begin
        ld_data = ext16(rd[DW-1 -: 16], sext);
        st_data = {wdata[15:0], rd[DW-17:0]};
      end
      SZ_W: begin
        ld_data = rd;
        st_data = wdata;
      end
      default: begin
        ld_data = '0;
        st_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU datapath and byte-banked data memory.
// One request at a time; sub-word stores are read-modify-write.
// Optional: MAU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_sext,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic          resp_err,
  output logic [DW-1:0] resp_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  mau_state_t    state, state_nx;
  logic          accept;
  logic          req_err;
  logic          we_q, sext_q, err_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] ld_data, st_data;

  assign accept = req_valid & req_ready;

  // Classify the incoming request as an error before any memory access
  always_comb begin
    req_err = (req_size == SZ_RSV);
`ifdef MAU_MISALIGN_TRAP_EN
    if ((req_size == SZ_H) && req_addr[0])
      req_err = 1'b1;
    if ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
      req_err = 1'b1;
`endif
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Request fields are held from accept until the response
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      sext_q  <= req_sext;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      err_q   <= req_err;
    end
  end

  // Memory data is valid in RDW, one cycle after the address was presented
  always_ff @(posedge clk) begin
    if (state == ST_RDW)
      rd_q <= mem_rdata;
  end

  mau_format #(.DW(DW)) u_format (
    .size    (size_q),
    .sext    (sext_q),
    .rd      (rd_q),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  // Next-state and output decode; every output idles at zero
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = rst_n;
        if (req_valid) begin
          if (req_err)
            state_nx = ST_RESP;
          else if (req_we && (req_size == SZ_W))
            state_nx = ST_WR;
          else
            state_nx = ST_RD;
        end
      end
      ST_RD: begin
        mem_read = 1'b1;
        mem_addr = addr_q;
        state_nx = ST_RDW;
      end
      ST_RDW: begin
        mem_read = 1'b1;
        mem_addr = addr_q;
        state_nx = we_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_write = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = st_data;
        state_nx  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : ld_data;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset
// sequences, and random traffic against a byte-array reference model.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_sext;
  logic [1:0]  req_size;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.AW(15), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Memory model: 32K bytes, 4-byte big-endian port with address wrap
  logic [7:0]  mem [32768];
  logic        mem_init_done = 1'b0;
  int          wr_count = 0;
  int          clash_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [14:0] last_waddr = '0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 8'h00;
      mem[16'h10] <= 8'h88; mem[16'h11] <= 8'h99; mem[16'h12] <= 8'hAA; mem[16'h13] <= 8'hBB;
      mem[16'h14] <= 8'h11; mem[16'h15] <= 8'h22; mem[16'h16] <= 8'h33; mem[16'h17] <= 8'h44;
      mem_init_done <= 1'b1;
    end else begin
      if (mem_read)
        mem_rdata <= {mem[mem_addr], mem[15'(mem_addr + 15'd1)],
                      mem[15'(mem_addr + 15'd2)], mem[15'(mem_addr + 15'd3)]};
      if (mem_write) begin
        mem[mem_addr]              <= mem_wdata[31:24];
        mem[15'(mem_addr + 15'd1)] <= mem_wdata[23:16];
        mem[15'(mem_addr + 15'd2)] <= mem_wdata[15:8];
        mem[15'(mem_addr + 15'd3)] <= mem_wdata[7:0];
        wr_count   <= wr_count + 1;
        last_wdata <= mem_wdata;
        last_waddr <= mem_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) clash_cnt <= clash_cnt + 1;
  end

  // Reference model: plain byte array holding the architectural memory image
  logic [7:0] ref_mem [32768];

  task automatic ref_txn(input logic we, input logic [1:0] size, input logic sext,
                         input logic [14:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int nwr);
    int n;
    logic [31:0] v;
    err = (size == SZ_RSV);
`ifdef MAU_MISALIGN_TRAP_EN
    if (size == SZ_H && addr[0]) err = 1'b1;
    if (size == SZ_W && addr[1:0] != 2'b00) err = 1'b1;
`endif
    n = (size == SZ_B) ? 1 : (size == SZ_H) ? 2 : 4;
    rdata = 32'h0; nwr = 0;
    if (err) begin
      lat = LAT_ERR;
    end else if (!we) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[(int'(addr) + i) % 32768]);
      if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rdata = v;
      lat = LAT_LD;
    end else begin
      for (int i = 0; i < n; i++)
        ref_mem[(int'(addr) + i) % 32768] = 8'(wdata >> (8*(n-1-i)));
      lat = (size == SZ_W) ? LAT_WST : LAT_SST;
      nwr = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request and observe its response (bounded wait)
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sext,
                         input logic [14:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nwr, output logic ready_after);
    int wr0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
    req_addr = addr; req_wdata = wdata;
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_sext = 1'($urandom); req_addr = 15'($urandom); req_wdata = $urandom;
    lat = 0; rdata = 32'h0; err = 1'b0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      if (resp_valid) begin lat = k; rdata = resp_rdata; err = resp_err; end
    end
    @(negedge clk);
    ready_after = req_ready;
    nwr = wr_count - wr0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rd, e_rd;
    logic        er, e_er, rdy;
    int          lat, nwr, e_lat, e_nwr, wr0;

    tbl[0]  = '{1'b0, SZ_B, 1'b0, 15'h0010, 32'h0, 32'h8899AABB, 1'b0, 3, 0, 32'h0};
    tbl[0].size = SZ_W;
    tbl[1]  = '{1'b0, SZ_B, 1'b1, 15'h0011, 32'h0, 32'hFFFFFF99, 1'b0, 3, 0, 32'h0};
    tbl[2]  = '{1'b0, SZ_B, 1'b0, 15'h0011, 32'h0, 32'h00000099, 1'b0, 3, 0, 32'h0};
    tbl[3]  = '{1'b0, SZ_H, 1'b1, 15'h0012, 32'h0, 32'hFFFFAABB, 1'b0, 3, 0, 32'h0};
    tbl[4]  = '{1'b1, SZ_B, 1'b0, 15'h0012, 32'h00000055, 32'h0, 1'b0, 4, 1, 32'h55BB1122};
    tbl[5]  = '{1'b0, SZ_W, 1'b0, 15'h0010, 32'h0, 32'h889955BB, 1'b0, 3, 0, 32'h0};
`ifdef MAU_MISALIGN_TRAP_EN
    tbl[6]  = '{1'b1, SZ_H, 1'b0, 15'h0011, 32'h00001234, 32'h0, 1'b1, 1, 0, 32'h0};
    tbl[7]  = '{1'b0, SZ_W, 1'b0, 15'h0010, 32'h0, 32'h889955BB, 1'b0, 3, 0, 32'h0};
`else
    tbl[6]  = '{1'b1, SZ_H, 1'b0, 15'h0011, 32'h00001234, 32'h0, 1'b0, 4, 1, 32'h1234BB11};
    tbl[7]  = '{1'b0, SZ_W, 1'b0, 15'h0010, 32'h0, 32'h881234BB, 1'b0, 3, 0, 32'h0};
`endif
    tbl[8]  = '{1'b0, SZ_RSV, 1'b0, 15'h0010, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0};
    tbl[9]  = '{1'b1, SZ_W, 1'b0, 15'h0014, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 32'hDEADBEEF};
    tbl[10] = '{1'b0, SZ_H, 1'b0, 15'h0014, 32'h0, 32'h0000DEAD, 1'b0, 3, 0, 32'h0};
    tbl[11] = '{1'b0, SZ_B, 1'b1, 15'h0016, 32'h0, 32'hFFFFFFBE, 1'b0, 3, 0, 32'h0};

    for (int i = 0; i < 32768; i++) ref_mem[i] = 8'h00;
    ref_mem[16'h10] = 8'h88; ref_mem[16'h11] = 8'h99; ref_mem[16'h12] = 8'hAA; ref_mem[16'h13] = 8'hBB;
    ref_mem[16'h14] = 8'h11; ref_mem[16'h15] = 8'h22; ref_mem[16'h16] = 8'h33; ref_mem[16'h17] = 8'h44;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_B;
    req_sext = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_outputs", {resp_valid, resp_err, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", {17'h0, mem_addr}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

    // Sub-word store aborted by reset during RDW: no write may happen
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_sext = 1'b0;
    req_addr = 15'h0010; req_wdata = 32'h000000AA;
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);          // RD
    @(negedge clk);          // RDW
    rst_n = 1'b0;
    #1 chk("abort_ready_low", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    chk("abort_idle_outputs", {resp_valid, mem_read, mem_write}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_release", {31'h0, req_ready}, 32'h1);
    chk("abort_no_write", wr_count - wr0, 32'h0);
    run_txn(1'b0, SZ_W, 1'b0, 15'h0010, 32'h0, rd, er, lat, nwr, rdy);
    chk("abort_lw", rd, 32'h8899AABB);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      ref_txn(tbl[i].we, tbl[i].size, tbl[i].sext, tbl[i].addr, tbl[i].wdata,
              e_rd, e_er, e_lat, e_nwr);
      run_txn(tbl[i].we, tbl[i].size, tbl[i].sext, tbl[i].addr, tbl[i].wdata,
              rd, er, lat, nwr, rdy);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_writes", i), nwr, tbl[i].exp_wr);
      chk($sformatf("vec%0d_ready", i), {31'h0, rdy}, 32'h1);
      if (tbl[i].exp_wr == 1) begin
        chk($sformatf("vec%0d_wdata", i), last_wdata, tbl[i].exp_wd);
        chk($sformatf("vec%0d_waddr", i), {17'h0, last_waddr}, {17'h0, tbl[i].addr});
      end
    end

    // Reset asserted in the WR cycle: that write completes, nothing after
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_sext = 1'b0;
    req_addr = 15'h0020; req_wdata = 32'hCAFEF00D;
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);          // WR
    rst_n = 1'b0;
    #1 chk("wrrst_write_in_wr", {31'h0, mem_write}, 32'h1);
    @(negedge clk);
    chk("wrrst_quiet", {resp_valid, mem_read, mem_write}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("wrrst_one_write", wr_count - wr0, 32'h1);
    ref_txn(1'b1, SZ_W, 1'b0, 15'h0020, 32'hCAFEF00D, e_rd, e_er, e_lat, e_nwr);

    // Random traffic against the reference model
    for (int t = 0; t < 150; t++) begin
      logic        we, sx;
      logic [1:0]  sz;
      logic [14:0] ad;
      logic [31:0] wd;
      we = 1'($urandom); sz = 2'($urandom); sx = 1'($urandom); wd = $urandom;
      ad = ($urandom_range(0, 7) == 0) ? 15'(15'h7FFC + 15'($urandom_range(0, 3)))
                                       : 15'($urandom_range(0, 63));
      ref_txn(we, sz, sx, ad, wd, e_rd, e_er, e_lat, e_nwr);
      run_txn(we, sz, sx, ad, wd, rd, er, lat, nwr, rdy);
      chk($sformatf("rnd%0d_rdata", t), rd, e_rd);
      chk($sformatf("rnd%0d_err", t), {31'h0, er}, {31'h0, e_er});
      chk($sformatf("rnd%0d_lat", t), lat, e_lat);
      chk($sformatf("rnd%0d_writes", t), nwr, e_nwr);
      chk($sformatf("rnd%0d_ready", t), {31'h0, rdy}, 32'h1);
    end

    // Whole memory image and read/write exclusivity
    begin
      int diff = 0;
      for (int i = 0; i < 32768; i++) if (mem[i] !== ref_mem[i]) diff++;
      chk("mem_image_diff", diff, 32'h0);
    end
    chk("rw_exclusive", clash_cnt, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
